// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a circular instruction queue feeding decode.
// Fetches 32-bit words over a req/done handshake; a redirect flushes and refetches.
module instr_fetch_queue #(
  parameter int QUEUE_ADDR_WIDTH = 3,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  clk_in,
  input  logic                  rstn_in,
  input  logic                  rdy_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_done,
  input  logic [31:0]           mem_data,
  input  logic                  flush_in,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  issue_in,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  has_instr
);

  localparam int DEPTH = 1 << QUEUE_ADDR_WIDTH;
  localparam int CW    = QUEUE_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t                      state, state_next;
  logic [QUEUE_ADDR_WIDTH-1:0] head, head_next, tail, tail_next;
  logic [CW-1:0]               count, count_next, count_after_pop;
  logic [ADDR_WIDTH-1:0]       fetch_pc, fetch_pc_next, mem_addr_next;
  logic                        mem_req_next;
  logic                        pop, push;

  logic [31:0]           instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_next      = state;
    head_next       = head;
    tail_next       = tail;
    count_next      = count;
    fetch_pc_next   = fetch_pc;
    mem_req_next    = mem_req;
    mem_addr_next   = mem_addr;
    pop             = 1'b0;
    push            = 1'b0;
    count_after_pop = count;

    if (rdy_in) begin
      if (flush_in) begin
        head_next     = '0;
        tail_next     = '0;
        count_next    = '0;
        fetch_pc_next = flush_pc;
        // An outstanding request must still be answered; its data is dropped.
        case (state)
          WAIT, DISCARD: begin
            if (mem_done) begin
              state_next   = IDLE;
              mem_req_next = 1'b0;
            end else begin
              state_next = DISCARD;
            end
          end
          default: state_next = IDLE;
        endcase
      end else begin
        pop             = issue_in && (count != '0);
        push            = (state == WAIT) && mem_done;
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        if (pop) head_next = head + QUEUE_ADDR_WIDTH'(1);
        if (push) begin
          tail_next     = tail + QUEUE_ADDR_WIDTH'(1);
          fetch_pc_next = fetch_pc + ADDR_WIDTH'(4);
        end

        case (state)
          IDLE: begin
            if (count_after_pop < DEPTH_CNT) begin
              mem_req_next  = 1'b1;
              mem_addr_next = fetch_pc;
              state_next    = WAIT;
            end
          end
          WAIT, DISCARD: begin
            if (mem_done) begin
              mem_req_next = 1'b0;
              state_next   = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_next;
      head     <= head_next;
      tail     <= tail_next;
      count    <= count_next;
      fetch_pc <= fetch_pc_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk_in) begin
    if (push) begin
      instr_mem[tail] <= mem_data;
      pc_mem[tail]    <= fetch_pc;
    end
  end

  assign has_instr = (count != '0);
  assign instr     = has_instr ? instr_mem[head] : '0;
  assign pc_out    = has_instr ? pc_mem[head] : '0;

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch unit and instruction queue sitting directly upstream of the issue/decode stage. It owns the fetch PC, fetches 32-bit instruction words from the memory controller over a request/done handshake, and buffers them in a circular FIFO. It presents the oldest buffered instruction, with its PC, to the decoder as `instr`/`has_instr`. A redirect from the branch/commit logic flushes the queue and restarts fetch at a new PC.

## Interface
Parameters:
- `QUEUE_ADDR_WIDTH`, default 3: log2 of queue depth; depth = 2^QUEUE_ADDR_WIDTH (8 entries).
- `ADDR_WIDTH`, default 32: PC / memory address width.

Ports:
- `clk_in`  in  1  the single clock; all state changes on its rising edge.
- `rstn_in`  in  1  reset, synchronous and active-low.
- `rdy_in`  in  1  global ready; when 0, all state holds (reset still applies).
- `mem_req`  out  1  fetch request to memory controller (registered).
- `mem_addr`  out  ADDR_WIDTH  fetch address (registered).
- `mem_done`  in  1  one-cycle pulse: `mem_data` valid for the outstanding request.
- `mem_data`  in  32  fetched instruction word.
- `flush_in`  in  1  redirect: discard queue and refetch.
- `flush_pc`  in  ADDR_WIDTH  new fetch PC when `flush_in`=1.
- `issue_in`  in  1  consumer pops the head entry this cycle.
- `instr`  out  32  head entry instruction; 0 when empty.
- `pc_out`  out  ADDR_WIDTH  head entry PC; 0 when empty.
- `has_instr`  out  1  queue non-empty.

## Operation
- Storage: DEPTH entries of {instr, pc}; `head`/`tail` pointers of QUEUE_ADDR_WIDTH bits, wrap naturally modulo DEPTH; `count` of QUEUE_ADDR_WIDTH+1 bits, range 0..DEPTH.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if `count` (after this cycle's pop) < DEPTH and no flush, set `mem_req`=1, `mem_addr`=`fetch_pc`, go WAIT.
  - WAIT: hold `mem_req`/`mem_addr` stable. On `mem_done`: write {`mem_data`, `fetch_pc`} at `tail`, `tail`+1, `fetch_pc`+=4, `mem_req`=0, go IDLE.
  - DISCARD: hold `mem_req`/`mem_addr` of the stale request. On `mem_done`: drop data, `mem_req`=0, go IDLE.
- Flush has top priority: `count`=0, `head`=`tail`=0, `fetch_pc`=`flush_pc`. Pops and any `mem_done` write in that cycle are ignored. Next state:
  - IDLE or WAIT with `mem_done`=1: go IDLE.
  - WAIT without `mem_done`: go DISCARD.
  - DISCARD: stay DISCARD unless `mem_done`=1, then go IDLE.
- Pop: if `issue_in` and `count`>0, `head`+1. `issue_in` when empty is ignored.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- Full: no new request while `count`==DEPTH; a pop in the same cycle frees space and allows a request.
- `fetch_pc` arithmetic is modulo 2^ADDR_WIDTH; wrap from 0xFFFFFFFC to 0 is legal.
- `rdy_in`=0: FSM, pointers, `count`, `fetch_pc`, `mem_req` and `mem_addr` all hold; `mem_done` is not expected while `rdy_in`=0.

## Timing
- Reset, with `rstn_in`=0 at an edge: state IDLE, `fetch_pc`=0, `head`=`tail`=`count`=0, `mem_req`=0, `mem_addr`=0. After that edge: `has_instr`=0, `instr`=0, `pc_out`=0.
- `has_instr`, `instr` and `pc_out` are combinational from registered state (`count`, `head`, storage).
- Request launch: `mem_req` rises the edge after IDLE sees space, so 1 cycle after reset or after the response edge.
- Entry visibility: the `mem_done` edge writes the entry; `has_instr`=1 from the next cycle.
- Throughput: at most one instruction per (memory latency + 1) cycles.
- Pop: `instr` shows the next entry the cycle after `issue_in`.
- Reset mid-request or during DISCARD: FSM returns to IDLE. A late `mem_done` arriving in IDLE is ignored.

## Test plan
- Reset then steady fetch: memory returns word A at addr N with 2-cycle latency, `issue_in`=0 → `mem_addr` sequence 0,4,8,…; 8 entries fill; `mem_req` stays 0 at `count`=8; `instr`=word@0, `pc_out`=0.
- Full plus pop: at `count`=8, pulse `issue_in` → same cycle allows a new request; next cycle `pc_out`=4; next `mem_addr`=0x20.
- Simultaneous push/pop at `count`=3 → `count` stays 3, head advances by one entry, tail advances by one entry.
- Flush in WAIT: request outstanding at 0x10, `flush_in` with `flush_pc`=0x100 → `has_instr`=0 next cycle; stale 0x10 response dropped; next `mem_addr`=0x100; first queued `pc_out`=0x100.
- Flush coincident with `mem_done` and `issue_in` → nothing written, `count`=0, state IDLE, next request to `flush_pc`.
- `rdy_in` low for 5 cycles mid-WAIT → all outputs frozen; operation resumes identically afterwards. PC wrap check: flush to 0xFFFFFFFC → next fetch address is 0.
